// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed segment scanner with per-digit PWM brightness and
// double-buffered digit data that is swapped at frame boundaries.
module seg_scan_ctrl #(
    parameter logic [31:0] PERIOD = 32'd5000,
    parameter logic [31:0] DEAD   = 32'd200,
    parameter logic [31:0] STEP   = 32'd300
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       wr_en,
    input  logic [1:0] wr_addr,
    input  logic [7:0] wr_seg,
    input  logic [3:0] wr_bri,
    input  logic       commit_req,
    output logic [7:0] seg,
    output logic [3:0] com,
    output logic       frame_tick,
    output logic       commit_ack
);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t      state_q, state_d;
    logic [31:0] slot_cnt_q, slot_cnt_d;
    logic [1:0]  digit_q, digit_d;
    logic        pending_q, pending_d;
    logic [7:0]  seg_q, seg_d;
    logic [3:0]  com_q, com_d;
    logic        frame_tick_q, frame_tick_d;
    logic        commit_ack_q, commit_ack_d;

    logic [7:0]  stg_seg_q [4];
    logic [7:0]  stg_seg_d [4];
    logic [3:0]  stg_bri_q [4];
    logic [3:0]  stg_bri_d [4];
    logic [7:0]  act_seg_q [4];
    logic [7:0]  act_seg_d [4];
    logic [3:0]  act_bri_q [4];
    logic [3:0]  act_bri_d [4];

    logic        req_any;
    logic        apply;
    logic        slot_wrap;
    logic        lit;
    logic [31:0] on_end;

    always_comb begin
        state_d      = state_q;
        slot_cnt_d   = slot_cnt_q;
        digit_d      = digit_q;
        stg_seg_d    = stg_seg_q;
        stg_bri_d    = stg_bri_q;
        act_seg_d    = act_seg_q;
        act_bri_d    = act_bri_q;
        seg_d        = '0;
        com_d        = '0;
        frame_tick_d = 1'b0;
        commit_ack_d = 1'b0;
        apply        = 1'b0;
        lit          = 1'b0;
        on_end       = '0;
        req_any      = pending_q | commit_req;
        slot_wrap    = (slot_cnt_q == PERIOD - 32'd1);

        case (state_q)
            IDLE: begin
                slot_cnt_d = '0;
                digit_d    = '0;
                apply      = req_any;
                if (en) state_d = SCAN;
            end
            SCAN: begin
                if (!en) begin
                    state_d    = IDLE;
                    slot_cnt_d = '0;
                    digit_d    = '0;
                end else if (slot_wrap) begin
                    slot_cnt_d = '0;
                    digit_d    = digit_q + 2'd1;
                    if (digit_q == 2'd3) begin
                        frame_tick_d = 1'b1;
                        apply        = req_any;
                    end
                end else begin
                    slot_cnt_d = slot_cnt_q + 32'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        pending_d = req_any & ~apply;

        // Copy uses the registered staging bank, so a same-cycle write is not taken.
        if (apply) begin
            act_seg_d    = stg_seg_q;
            act_bri_d    = stg_bri_q;
            commit_ack_d = 1'b1;
        end

        if (wr_en) begin
            stg_seg_d[wr_addr] = wr_seg;
            stg_bri_d[wr_addr] = wr_bri;
        end

        if (state_d == SCAN) begin
            lit    = (slot_cnt_d >= DEAD);
            on_end = DEAD + ({28'd0, act_bri_d[digit_d]} * STEP);
            com_d  = lit ? (4'b0001 << digit_d) : 4'b0000;
            seg_d  = (lit && (slot_cnt_d < on_end)) ? act_seg_d[digit_d] : 8'h00;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            slot_cnt_q   <= '0;
            digit_q      <= '0;
            pending_q    <= 1'b0;
            seg_q        <= '0;
            com_q        <= '0;
            frame_tick_q <= 1'b0;
            commit_ack_q <= 1'b0;
            stg_seg_q    <= '{default: '0};
            stg_bri_q    <= '{default: '0};
            act_seg_q    <= '{default: '0};
            act_bri_q    <= '{default: '0};
        end else begin
            state_q      <= state_d;
            slot_cnt_q   <= slot_cnt_d;
            digit_q      <= digit_d;
            pending_q    <= pending_d;
            seg_q        <= seg_d;
            com_q        <= com_d;
            frame_tick_q <= frame_tick_d;
            commit_ack_q <= commit_ack_d;
            stg_seg_q    <= stg_seg_d;
            stg_bri_q    <= stg_bri_d;
            act_seg_q    <= act_seg_d;
            act_bri_q    <= act_bri_d;
        end
    end

    assign seg        = seg_q;
    assign com        = com_q;
    assign frame_tick = frame_tick_q;
    assign commit_ack = commit_ack_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: directed scenarios plus random traffic, checked
// every cycle against a time-based reference model.
module tb_seg_scan_ctrl;

    localparam int P     = 20;
    localparam int DEAD  = 2;
    localparam int STEP  = 1;
    localparam int FRAME = 4 * P;

    logic       clk = 1'b0;
    logic       rst, en, wr_en, commit_req;
    logic [1:0] wr_addr;
    logic [7:0] wr_seg;
    logic [3:0] wr_bri;
    logic [7:0] seg;
    logic [3:0] com;
    logic       frame_tick, commit_ack;

    int n_assert = 0;
    int n_fail   = 0;

    // Model: t counts cycles since SCAN entry; digit and slot position derive from it.
    int m_stg_seg [4];
    int m_stg_bri [4];
    int m_act_seg [4];
    int m_act_bri [4];
    bit m_scan, m_pend;
    int m_t;
    int e_seg, e_com, e_tick, e_ack;

    always #5 clk = ~clk;

    seg_scan_ctrl #(
        .PERIOD(32'd20),
        .DEAD  (32'd2),
        .STEP  (32'd1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_seg    (wr_seg),
        .wr_bri    (wr_bri),
        .commit_req(commit_req),
        .seg       (seg),
        .com       (com),
        .frame_tick(frame_tick),
        .commit_ack(commit_ack)
    );

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) begin
            m_stg_seg[i] = 0; m_stg_bri[i] = 0;
            m_act_seg[i] = 0; m_act_bri[i] = 0;
        end
        m_scan = 0; m_pend = 0; m_t = 0;
        e_seg = 0; e_com = 0; e_tick = 0; e_ack = 0;
    endfunction

    function automatic void model_step();
        bit req, apply;
        int d, c;
        if (!rst) begin
            model_reset();
            return;
        end
        req    = m_pend | commit_req;
        apply  = 0;
        e_tick = 0;
        if (!m_scan) apply = req;
        else if (en && ((m_t + 1) % FRAME == 0)) begin
            e_tick = 1;
            apply  = req;
        end
        m_pend = req && !apply;
        if (apply) begin
            for (int i = 0; i < 4; i++) begin
                m_act_seg[i] = m_stg_seg[i];
                m_act_bri[i] = m_stg_bri[i];
            end
        end
        if (wr_en) begin
            m_stg_seg[wr_addr] = wr_seg;
            m_stg_bri[wr_addr] = wr_bri;
        end
        if (en) begin
            m_t    = m_scan ? m_t + 1 : 0;
            m_scan = 1;
        end else begin
            m_scan = 0;
        end
        e_ack = apply;
        e_seg = 0;
        e_com = 0;
        if (m_scan) begin
            d = (m_t / P) % 4;
            c = m_t % P;
            if (c >= DEAD) begin
                e_com = 1 << d;
                if (c < DEAD + m_act_bri[d] * STEP) e_seg = m_act_seg[d];
            end
        end
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check("seg", {24'd0, seg}, e_seg);
        check("com", {28'd0, com}, e_com);
        check("frame_tick", {31'd0, frame_tick}, e_tick);
        check("commit_ack", {31'd0, commit_ack}, e_ack);
    endtask

    initial begin
        bit found;
        rst = 1'b0; en = 1'b0; wr_en = 1'b0; commit_req = 1'b0;
        wr_addr = '0; wr_seg = '0; wr_bri = '0;
        model_reset();
        #1;
        check("reset_seg", {24'd0, seg}, 0);
        check("reset_com", {28'd0, com}, 0);
        check("reset_tick", {31'd0, frame_tick}, 0);
        check("reset_ack", {31'd0, commit_ack}, 0);
        repeat (3) tick();
        rst = 1'b1;
        repeat (2) tick();

        // Digit 0 full brightness, committed while idle, then scan.
        wr_en = 1'b1; wr_addr = 2'd0; wr_seg = 8'hFF; wr_bri = 4'd15;
        tick();
        wr_en = 1'b0; commit_req = 1'b1;
        tick();
        commit_req = 1'b0;
        repeat (3) tick();
        en = 1'b1;
        repeat (100) tick();

        // Mid-frame commit of digit 1, applied at the frame wrap.
        wr_en = 1'b1; wr_addr = 2'd1; wr_seg = 8'h3C; wr_bri = 4'd4;
        tick();
        wr_en = 1'b0; commit_req = 1'b1;
        tick();
        commit_req = 1'b0;
        repeat (200) tick();

        // Commit on the wrap cycle with a same-cycle write to digit 2.
        wr_en = 1'b1; wr_addr = 2'd2; wr_seg = 8'h55; wr_bri = 4'd6;
        tick();
        wr_en = 1'b0;
        found = 0;
        for (int k = 0; k < 200 && !found; k++) begin
            if (m_scan && ((m_t + 1) % FRAME == 0)) found = 1;
            else tick();
        end
        check("wrap_found", {31'd0, found}, 1);
        commit_req = 1'b1;
        wr_en = 1'b1; wr_addr = 2'd2; wr_seg = 8'hAA; wr_bri = 4'd9;
        tick();
        commit_req = 1'b0; wr_en = 1'b0;
        repeat (100) tick();

        // Drop enable at digit 2, slot count 10, then restart.
        found = 0;
        for (int k = 0; k < 200 && !found; k++) begin
            if (m_scan && (m_t % FRAME == 2 * P + 10)) found = 1;
            else tick();
        end
        check("d2c10_found", {31'd0, found}, 1);
        en = 1'b0;
        repeat (6) tick();
        en = 1'b1;
        repeat (90) tick();

        // Random traffic.
        repeat (1500) begin
            en         = ($urandom_range(0, 99) != 0);
            wr_en      = ($urandom_range(0, 3) == 0);
            wr_addr    = 2'($urandom_range(0, 3));
            wr_seg     = 8'($urandom_range(0, 255));
            wr_bri     = 4'($urandom_range(0, 15));
            commit_req = ($urandom_range(0, 29) == 0);
            tick();
        end
        en = 1'b1; wr_en = 1'b0; commit_req = 1'b0;
        repeat (5) tick();

        // Asynchronous reset mid-slot with a commit pending.
        found = 0;
        for (int k = 0; k < 200 && !found; k++) begin
            if (m_scan && (m_t % P == 8)) found = 1;
            else tick();
        end
        check("midslot_found", {31'd0, found}, 1);
        commit_req = 1'b1;
        tick();
        commit_req = 1'b0;
        repeat (3) tick();
        check("pending_before_rst", {31'd0, m_pend}, 1);
        #2 rst = 1'b0;
        #1;
        model_reset();
        check("async_seg", {24'd0, seg}, 0);
        check("async_com", {28'd0, com}, 0);
        check("async_tick", {31'd0, frame_tick}, 0);
        check("async_ack", {31'd0, commit_ack}, 0);
        repeat (2) tick();
        rst = 1'b1;
        repeat (170) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
